// File: rtl/eth_tx.sv
// RMII transmit MAC: preamble/SFD framing, pad to 60 bytes, CRC-32 FCS,
// one dibit per clock, interframe gap enforcement.
module eth_tx #(
    parameter int IFG_CYCLES = 48,
    parameter int MAX_LEN    = 1514
) (
    input  logic       clk_mac,
    input  logic       rst_n,
    input  logic       tx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_sof,
    input  logic       tx_eof,
    output logic       tx_rdy,
    output logic       tx_err,
    output logic       tx_busy,
    output logic       eth_txen,
    output logic [1:0] eth_txd
);
    localparam int IW = $clog2(IFG_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_dib, w_dib;
    logic [2:0]      r_idx, w_idx;
    logic [7:0]      r_byte, w_byte;
    logic            r_last, w_last;
    logic [10:0]     r_cnt, w_cnt;
    logic [31:0]     r_crc, w_crc;
    logic            r_drop, w_drop;
    logic [IW-1:0]   r_ifg, w_ifg;
    logic            w_err, w_txen, w_rdy, w_acc;
    logic [1:0]      w_d;

    function automatic logic [31:0] crc2(input logic [31:0] c,
                                         input logic [1:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 2; i++)
            x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return x;
    endfunction

    assign w_acc = tx_vld && tx_rdy;

    always_comb begin
        w_state = r_state;
        w_dib   = r_dib;
        w_idx   = r_idx;
        w_byte  = r_byte;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_crc   = r_crc;
        w_drop  = r_drop;
        w_ifg   = r_ifg;
        w_err   = 1'b0;
        w_txen  = 1'b0;
        w_d     = 2'b00;
        // Tail of an oversize frame is swallowed up to its EOF
        if (r_drop && w_acc && tx_eof)
            w_drop = 1'b0;
        if (r_state != S_IDLE)
            w_dib = r_dib + 2'd1;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && !r_drop && tx_sof) begin
                    w_state = S_PRE;
                    w_dib   = 2'd0;
                    w_idx   = 3'd0;
                    w_byte  = tx_dat;
                    w_last  = tx_eof;
                    w_cnt   = 11'd1;
                    w_crc   = '1;
                end
            end
            S_PRE: begin
                if (r_dib == 2'd3) begin
                    if (r_idx == 3'd7) w_state = S_DATA;
                    else               w_idx   = r_idx + 3'd1;
                end
            end
            S_DATA: begin
                if (r_dib == 2'd3) begin
                    if (r_last) begin
                        if (r_cnt < 11'd60) begin
                            w_state = S_PAD;
                            w_byte  = 8'h00;
                            w_cnt   = r_cnt + 11'd1;
                        end else begin
                            w_state = S_FCS;
                            w_idx   = 3'd0;
                        end
                    end else if (w_acc) begin
                        w_byte = tx_dat;
                        w_cnt  = (r_cnt >= 11'(MAX_LEN)) ? r_cnt
                                                         : r_cnt + 11'd1;
                        w_last = tx_eof || (w_cnt == 11'(MAX_LEN));
                        if (!tx_eof && w_cnt == 11'(MAX_LEN)) begin
                            w_err  = 1'b1;
                            w_drop = 1'b1;
                        end
                    end else begin
                        w_state = S_IFG;
                        w_ifg   = '0;
                        w_err   = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (r_dib == 2'd3) begin
                    if (r_cnt >= 11'd60) begin
                        w_state = S_FCS;
                        w_idx   = 3'd0;
                    end else begin
                        w_cnt = r_cnt + 11'd1;
                    end
                end
            end
            S_FCS: begin
                if (r_dib == 2'd3) begin
                    if (r_idx == 3'd3) begin
                        w_state = S_IFG;
                        w_ifg   = '0;
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end
            end
            S_IFG: begin
                // Last gap cycle is spent in IDLE with tx_rdy already high
                if (r_ifg == IW'(IFG_CYCLES - 2)) w_state = S_IDLE;
                else                              w_ifg   = r_ifg + IW'(1);
            end
            default: w_state = S_IDLE;
        endcase
        unique case (w_state)
            S_PRE: begin
                w_txen = 1'b1;
                w_d    = (w_idx == 3'd7 && w_dib == 2'd3) ? 2'b11 : 2'b01;
            end
            S_DATA, S_PAD: begin
                w_txen = 1'b1;
                w_d    = w_byte[{w_dib, 1'b0} +: 2];
                w_crc  = crc2(r_crc, w_d);
            end
            S_FCS: begin
                w_txen = 1'b1;
                w_d    = ~r_crc[1:0];
                w_crc  = {2'b00, r_crc[31:2]};
            end
            default: ;
        endcase
        w_rdy = w_drop || (w_state == S_IDLE) ||
                (w_state == S_DATA && w_dib == 2'd3 && !w_last);
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dib    <= '0;
            r_idx    <= '0;
            r_byte   <= '0;
            r_last   <= 1'b0;
            r_cnt    <= '0;
            r_crc    <= '1;
            r_drop   <= 1'b0;
            r_ifg    <= '0;
            tx_rdy   <= 1'b0;
            tx_err   <= 1'b0;
            tx_busy  <= 1'b0;
            eth_txen <= 1'b0;
            eth_txd  <= 2'b00;
        end else begin
            r_state  <= w_state;
            r_dib    <= w_dib;
            r_idx    <= w_idx;
            r_byte   <= w_byte;
            r_last   <= w_last;
            r_cnt    <= w_cnt;
            r_crc    <= w_crc;
            r_drop   <= w_drop;
            r_ifg    <= w_ifg;
            tx_rdy   <= w_rdy;
            tx_err   <= w_err;
            tx_busy  <= (w_state != S_IDLE);
            eth_txen <= w_txen;
            eth_txd  <= w_d;
        end
    end
endmodule

// File: tb/tb_eth_tx.sv
// Bench for eth_tx: byte-level frame model with FCS, per-cycle monitor,
// directed frames covering padding, IFG, underflow, oversize and reset.
module tb_eth_tx;
    logic       clk_mac = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tx_vld  = 1'b0;
    logic [7:0] tx_dat  = 8'h00;
    logic       tx_sof  = 1'b0;
    logic       tx_eof  = 1'b0;
    logic       tx_rdy, tx_err, tx_busy, eth_txen;
    logic [1:0] eth_txd;

    eth_tx #(.IFG_CYCLES(48), .MAX_LEN(1514)) dut (
        .clk_mac(clk_mac), .rst_n(rst_n),
        .tx_vld(tx_vld), .tx_dat(tx_dat),
        .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_rdy(tx_rdy), .tx_err(tx_err), .tx_busy(tx_busy),
        .eth_txen(eth_txen), .eth_txd(eth_txd)
    );

    always #10 clk_mac = ~clk_mac;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_mac) cyc <= cyc + 1;

    logic [7:0] pay [0:1599];
    int         acc_c [0:1599];
    int         exp_kind [$];
    int         exp_len [$];
    logic [7:0] exp_b [$];

    int fi = 0;
    int rise_c [0:31];
    int fall_c [0:31];
    int hi_c [0:31];
    int gap_c [0:31];
    int lastfall = 0;
    int err_cycles = 0;
    int err_c = 0;
    int rdy_cnt = 0;
    logic p_txen = 1'b0;
    logic [1:0] dq [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] q[$],
                                          input int from);
        logic [31:0] r;
        r = '1;
        for (int i = from; i < q.size(); i++) begin
            r ^= {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    // kind 0: full frame with pad+FCS, 1: truncated (no FCS), 2: unchecked
    task automatic add_exp(input int n, input int kind);
        logic [7:0] d [$];
        logic [31:0] c;
        exp_kind.push_back(kind);
        if (kind == 2) begin
            exp_len.push_back(0);
            return;
        end
        for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        for (int i = 0; i < n; i++) d.push_back(pay[i]);
        if (kind == 0)
            while (d.size() < 60) d.push_back(8'h00);
        c = crc32(d, 0);
        foreach (d[i]) exp_b.push_back(d[i]);
        if (kind == 0)
            for (int i = 0; i < 4; i++) exp_b.push_back(c[8*i +: 8]);
        exp_len.push_back(8 + d.size() + ((kind == 0) ? 4 : 0));
    endtask

    task automatic check_frame();
        logic [7:0] rb [$];
        logic [7:0] e [$];
        int kind, len, mism;
        for (int i = 0; i + 3 < dq.size(); i += 4)
            rb.push_back({dq[i+3], dq[i+2], dq[i+1], dq[i]});
        if (exp_kind.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0d bytes want none",
                     rb.size());
            return;
        end
        kind = exp_kind.pop_front();
        len  = exp_len.pop_front();
        for (int i = 0; i < len; i++) e.push_back(exp_b.pop_front());
        if (kind == 2) return;
        chk("frame_len", rb.size(), len);
        mism = -1;
        for (int i = 0; i < len && i < rb.size(); i++)
            if (mism < 0 && rb[i] !== e[i]) mism = i;
        if (mism >= 0)
            $display("  frame %0d byte %0d got %h want %h",
                     fi, mism, rb[mism], e[mism]);
        chk("frame_bytes", mism, -1);
        if (kind == 0)
            chk("fcs_residue", crc32(rb, 8), 32'h2144DF1C);
    endtask

    always @(negedge clk_mac) begin
        if (tx_err) begin
            err_cycles++;
            err_c = cyc;
        end
        if (tx_busy && tx_rdy) rdy_cnt++;
        if (eth_txen) begin
            if (!p_txen) begin
                rise_c[fi] = cyc;
                gap_c[fi]  = cyc - lastfall;
            end
            dq.push_back(eth_txd);
        end else begin
            chk("txd_idle", eth_txd, 2'b00);
            if (p_txen) begin
                check_frame();
                fall_c[fi] = cyc;
                hi_c[fi]   = dq.size();
                lastfall   = cyc;
                fi++;
                dq.delete();
            end
        end
        p_txen = eth_txen;
    end

    task automatic push(input logic [7:0] d, input logic s, input logic e,
                        output int ac);
        int n;
        n = 0;
        @(negedge clk_mac);
        tx_vld = 1'b1;
        tx_dat = d;
        tx_sof = s;
        tx_eof = e;
        while (!tx_rdy && n < 8000) begin
            @(negedge clk_mac);
            n++;
        end
        chk("push_rdy", tx_rdy, 1'b1);
        ac = cyc;
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++)
            push(pay[k], k == 0, k == n - 1, acc_c[k]);
    endtask

    task automatic idle_in();
        @(negedge clk_mac);
        tx_vld = 1'b0;
        tx_sof = 1'b0;
        tx_eof = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (fi < n && t < 20000) begin
            @(negedge clk_mac);
            t++;
        end
        chk("frame_seen", fi >= n, 1'b1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((tx_busy || !tx_rdy) && t < 5000) begin
            @(negedge clk_mac);
            t++;
        end
        chk("idle_reached", {tx_busy, tx_rdy}, 2'b01);
    endtask

    initial begin
        logic [7:0] s9 [$];
        int f, f2, e0, sp;

        for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
        chk("model_crc_check", crc32(s9, 0), 32'hCBF43926);

        #35;
        chk("reset_outs", {tx_rdy, tx_err, tx_busy, eth_txen, eth_txd},
            6'b0);
        @(negedge clk_mac) rst_n = 1'b1;
        @(negedge clk_mac);
        chk("rdy_after_reset", tx_rdy, 1'b1);

        // 1-byte frame, padded to 60
        pay[0] = 8'hAB;
        f = fi;
        add_exp(1, 0);
        send(1);
        idle_in();
        chk("sof_busy", {tx_busy, eth_txen}, 2'b11);
        wait_frames(f + 1);
        chk("len1_txen", hi_c[f], 288);
        chk("len1_rise", rise_c[f] - acc_c[0], 1);

        // 64-byte frame, vld always high
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        wait_idle();
        rdy_cnt = 0;
        f = fi;
        add_exp(64, 0);
        send(64);
        idle_in();
        wait_frames(f + 1);
        wait_idle();
        chk("len64_txen", hi_c[f], 304);
        chk("len64_rdy_pulses", rdy_cnt, 63);
        chk("len64_first_rdy", acc_c[1] - acc_c[0], 36);
        sp = 0;
        for (int k = 1; k < 63; k++)
            if (acc_c[k+1] - acc_c[k] != 4) sp++;
        chk("len64_rdy_spacing", sp, 0);

        // back-to-back 60-byte frames
        for (int i = 0; i < 60; i++) pay[i] = 8'(i * 29 + 5);
        f = fi;
        add_exp(60, 0);
        add_exp(60, 0);
        send(60);
        send(60);
        idle_in();
        wait_frames(f + 2);
        chk("b2b_txen_a", hi_c[f], 288);
        chk("b2b_txen_b", hi_c[f+1], 288);
        chk("b2b_gap", gap_c[f+1], 48);
        chk("b2b_sof_cycle", acc_c[0] - fall_c[f], 47);

        // underflow after 10 bytes
        wait_idle();
        for (int i = 0; i < 100; i++) pay[i] = 8'(i + 100);
        f = fi;
        e0 = err_cycles;
        add_exp(10, 1);
        for (int k = 0; k < 10; k++)
            push(pay[k], k == 0, 1'b0, acc_c[k]);
        idle_in();
        wait_frames(f + 1);
        repeat (4) @(negedge clk_mac);
        chk("uf_err_once", err_cycles - e0, 1);
        chk("uf_err_at_fall", err_c, fall_c[f]);
        chk("uf_txen", hi_c[f], 72);

        // oversize: 1600 bytes, EOF only on the last
        wait_idle();
        for (int i = 0; i < 1600; i++) pay[i] = 8'(i * 37 + 11);
        f = fi;
        e0 = err_cycles;
        add_exp(1514, 0);
        send(1600);
        idle_in();
        wait_frames(f + 1);
        wait_idle();
        chk("ov_txen", hi_c[f], 6104);
        chk("ov_err_once", err_cycles - e0, 1);
        chk("ov_err_cycle", err_c - acc_c[1513], 1);
        repeat (60) @(negedge clk_mac);
        chk("ov_no_extra_frame", fi, f + 1);
        chk("ov_idle", {tx_busy, tx_rdy}, 2'b01);

        // asynchronous reset during DATA
        for (int i = 0; i < 60; i++) pay[i] = 8'(i) ^ 8'h5A;
        f = fi;
        add_exp(0, 2);
        for (int k = 0; k < 5; k++)
            push(pay[k], k == 0, 1'b0, acc_c[k]);
        @(posedge clk_mac);
        #3;
        rst_n  = 1'b0;
        tx_vld = 1'b0;
        tx_sof = 1'b0;
        tx_eof = 1'b0;
        #1;
        chk("reset_async", {tx_rdy, tx_err, tx_busy, eth_txen, eth_txd},
            6'b0);
        @(negedge clk_mac) rst_n = 1'b1;
        @(negedge clk_mac);
        chk("rdy_after_rst", tx_rdy, 1'b1);
        f2 = fi;
        add_exp(60, 0);
        send(60);
        idle_in();
        wait_frames(f2 + 1);
        chk("post_rst_txen", hi_c[f2], 288);
        chk("err_total", err_cycles, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_tx.md
# eth_tx

RMII transmit MAC for the 100 Mb/s Ethernet path. The block accepts a byte stream with a per-byte ready/valid handshake and frame markers. It frames each packet with preamble and SFD, pads it to the 60-byte minimum, appends the IEEE 802.3 FCS, and drives the RMII TX pins one dibit per `clk_mac` cycle. It enforces the interframe gap. It is the transmit counterpart of `eth_rx` and sits between the user/packet logic and the PHY.

## Interface
- `IFG_CYCLES`, 48: interframe gap in `clk_mac` cycles (12 byte times), with `eth_txen` low.
- `MAX_LEN`, 1514: maximum number of user bytes per frame, excluding FCS.
- `clk_mac`  in  1  50 MHz RMII reference clock. This is the only clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `tx_vld`  in  1  User byte valid.
- `tx_dat`  in  8  User byte. Transmitted LSB dibit first.
- `tx_sof`  in  1  Marks the first byte of a frame. Qualified by `tx_vld`.
- `tx_eof`  in  1  Marks the last byte of a frame. Qualified by `tx_vld`. May coincide with `tx_sof`.
- `tx_rdy`  out  1  Byte accepted in a cycle with `tx_vld && tx_rdy`.
- `tx_err`  out  1  One-cycle pulse when a frame is aborted (underflow) or truncated (oversize).
- `tx_busy`  out  1  High from SOF acceptance through the end of the IFG.
- `eth_txen`  out  1  RMII TX_EN.
- `eth_txd`  out  2  RMII TXD[1:0].

## Operation
- All outputs are registered. The reset value of every output is 0. Reset forces state IDLE, clears all counters, and clears the CRC register to all ones.
- The block has six states: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- A 2-bit dibit counter runs in every non-IDLE state. A byte boundary occurs when the counter wraps from 3 to 0.
- **IDLE**
  - `tx_rdy` = 1.
  - A byte accepted with `tx_sof` = 1 is latched into the holding register, `byte_cnt` = 1, and the state moves to PREAMBLE.
  - A byte accepted without `tx_sof` is discarded.
- **PREAMBLE**
  - Sends 28 dibits of 2'b01 (seven 0x55 bytes).
  - Then sends the SFD 0xD5 as the dibits 01, 01, 01, 11.
  - The state then moves to DATA, beginning with the held byte.
- **DATA**
  - Shifts the current byte out as `dat[1:0]`, `[3:2]`, `[5:4]`, `[7:6]`.
  - Each byte is fed into the CRC-32 as it is shifted: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - If the current byte is not EOF, `tx_rdy` is high during its 4th dibit. That is also the 4th dibit of the SFD for the first data byte. The accepted byte follows with no gap.
  - **Underflow:** if `tx_vld` = 0 while `tx_rdy` = 1:
    - `eth_txen` drops on the next cycle and the FCS is not sent.
    - `tx_err` pulses.
    - The state moves to IFG.
  - **Oversize:** the byte that brings `byte_cnt` to `MAX_LEN` without `tx_eof` is treated as EOF and `tx_err` pulses. Upstream bytes up to and including its EOF are then accepted and dropped.
  - `tx_sof` on a mid-frame byte is ignored; the byte is sent as data.
- **EOF handling**
  - If `byte_cnt` < 60, the state moves to PAD.
  - Otherwise the state moves to FCS.
- **PAD**
  - Sends 0x00 bytes, including them in the CRC, until 60 bytes have been sent in total.
- **FCS**
  - Sends `~crc` as 4 bytes, least-significant byte first, each byte LSB dibit first.
  - `tx_rdy` = 0.
- **IFG**
  - `eth_txen` = 0 and `eth_txd` = 0 for `IFG_CYCLES` cycles.
  - Then the state moves to IDLE and `tx_busy` drops.
- `byte_cnt` is 11 bits and saturates at `MAX_LEN`.
- `eth_txd` = 0 whenever `eth_txen` = 0.

## Timing
- SOF accepted at cycle N: `eth_txen` rises at N+1 with the first preamble dibit.
- The SFD occupies cycles N+29 to N+32. The first data dibit appears at N+33.
- Frame with L user bytes: `eth_txen` is high for 4·(8 + max(L,60) + 4) consecutive cycles.
- Data byte k (0-based) occupies cycles N+33+4k to N+36+4k. `tx_rdy` for byte k+1 is high at N+36+4k.
- The earliest next SOF acceptance is the first cycle after IFG: `tx_rdy` returns high `IFG_CYCLES` cycles after the last FCS dibit.
- Asynchronous reset mid-frame:
  - `eth_txen` and all other outputs go to 0 immediately.
  - After reset releases, `tx_rdy` goes high on the first clock edge.
  - The partial frame is not resumed.
- `tx_err` is high for exactly one cycle: the cycle after the underflow or oversize condition is detected.

## Test plan
- **1-byte frame:** 0xAB with SOF and EOF.
  - `eth_txen` is high for 288 cycles: 8 preamble/SFD bytes, 0xAB, 59 × 0x00, then 4 FCS bytes.
  - Looped into `eth_rx`, this gives `rx_err` = 0 and 60 bytes delivered.
- **64-byte frame, payload bytes 0x00 to 0x3F, `tx_vld` always high:**
  - `eth_txen` is high for 304 cycles.
  - Exactly one `tx_rdy` pulse per byte, 4 cycles apart.
  - The FCS matches the software CRC-32 reference model.
  - Looped into `eth_rx`, this gives `rx_err` = 0.
- **Back-to-back 60-byte frames:**
  - `eth_txen` is low for exactly 48 cycles between them.
  - The second SOF is accepted on the first cycle `tx_rdy` = 1.
- **Underflow:** `tx_vld` is dropped at byte 10 of a 100-byte frame.
  - `tx_err` pulses once.
  - `eth_txen` falls the next cycle and no FCS is sent.
  - Looped into `eth_rx`, this gives `rx_err` = 1.
- **Oversize:** 1600 bytes with no EOF until byte 1600.
  - 1514 bytes are transmitted, followed by a valid FCS.
  - `tx_err` pulses once.
  - The remaining 86 bytes are accepted and dropped.
  - The block returns to IDLE.
- **Reset mid-frame:** `rst_n` is asserted during DATA.
  - `eth_txen` = 0 asynchronously.
  - After release, a new 60-byte frame transmits correctly.
